tk1_rewind: RTL and testbench
=============================

# tk1_rewind

Iterative inverse of the TK1 tweakey permutation. It takes a TK1 word that has been advanced by N applications of the H permutation and recovers the original TK1. It applies up to four inverse-H steps per cycle. It sits beside the forward 4-step TK1 permuter in the Romulus datapath. It lets the controller restore TK1 after a block without re-loading it from the tweak/nonce registers.

## Interface

Parameters:

- STEPS_PER_CYCLE, 4 — inverse-H steps applied per RUN cycle; must divide 16.
- CNT_W, 6 — width of the step-count input.

Ports:

- clk, input, 1 — single clock; all state updates on the rising edge.
- rst, input, 1 — synchronous, active-high reset.
- in_valid, input, 1 — request valid.
- in_ready, output, 1 — block can accept a request (high only in IDLE).
- tk1_in, input, 64 — permuted TK1.
- nsteps, input, CNT_W — number of forward H steps to undo.
- ad, input, 1 — bypass: result = tk1_in unchanged (associated-data path).
- out_valid, output, 1 — result valid; held until accepted.
- out_ready, input, 1 — consumer accepts result.
- tk1_out, output, 64 — recovered TK1; registered.

## Operation

- Cell layout: 16 nibble cells; cell i = tk1[63-4i -: 4] (cell 0 is the MSB nibble).
- Forward H: out[i] = in[P[i]], with P = 9,15,8,13,10,14,12,11,0,1,2,3,4,5,6,7.
- Inverse H (this block): out[i] = in[Q[i]], with Q = 8,9,10,11,12,13,14,15,2,0,4,7,6,3,5,1.
- H has order 16, so the effective count is r = nsteps mod 16 (the low 4 bits); if ad = 1, r = 0.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, latch tk1_in into the state register and r into the remaining counter.
    - Go to RUN if r ≠ 0.
    - Go to DONE if r = 0.
  - RUN: apply min(STEPS_PER_CYCLE, remaining) inverse steps; decrement remaining by that amount.
    - Go to DONE when remaining reaches 0.
  - DONE: out_valid = 1 and tk1_out is stable.
    - On out_ready, go to IDLE.
- Step selection is a mux over the outputs of a chain of STEPS_PER_CYCLE inverse-H stages, indexed by min(STEPS_PER_CYCLE, remaining).
- in_valid outside IDLE is ignored. Inputs are sampled only at the accepting edge; later changes to tk1_in, nsteps or ad have no effect.

## Timing

- Reset values: state = IDLE, in_ready = 1, out_valid = 0, tk1_out = 64'h0, remaining = 0.
- Handshake at edge E0. Let k = ceil(r / STEPS_PER_CYCLE), so k = 0..4 for the defaults.
- out_valid rises after edge E0+k. It is visible in the cycle following E0+k (1 cycle when k = 0, 5 cycles at most).
- out_valid falls on the edge where out_valid and out_ready are both high. in_ready rises on that same edge.
- Back-to-back requests therefore cost one bubble cycle; DONE never accepts a new request.
- out_ready being held high before out_valid rises is legal. The result is consumed on the first out_valid cycle.
- Reset mid-RUN or mid-DONE:
  - Returns to IDLE on the next edge.
  - Drops out_valid and clears tk1_out.
  - No partial result is ever presented.
- Boundary counts:
  - nsteps = 16, 32 or 48 behaves exactly as nsteps = 0 (k = 0).
  - nsteps = 63 behaves as r = 15 (k = 4; the last RUN cycle applies 3 steps).

## Structure

- Package tk1_perm_pkg holds:
  - the P and Q index constants;
  - the cell width (4) and cell count (16);
  - the FSM state enum {IDLE, RUN, DONE}.
- Sub-module hperm_inv: purely combinational single inverse-H step, 64-bit in/out. tk1_rewind instantiates STEPS_PER_CYCLE copies in a chain.
- The top holds the FSM, the 64-bit state register, the 4-bit remaining counter and the output register.

## Test plan

- Single step: tk1_in = 64'h0123456789ABCDEF, nsteps = 1, ad = 0 -> tk1_out = 64'h89ABCDEF20476351, out_valid in the 2nd cycle after the handshake.
- Round trip: tk1_in = 64'h9F8DAECB01234567 (forward H once of the identity), nsteps = 1 -> 64'h0123456789ABCDEF. Then, for random X and nsteps in 0..63: drive the forward-H model nsteps times, rewind, check the result equals X and out_valid arrives after ceil((nsteps mod 16)/4) + 1 cycles.
- Modulo and bypass:
  - nsteps = 16 -> tk1_out = tk1_in after 1 cycle.
  - nsteps = 5 with ad = 1 -> tk1_out = tk1_in after 1 cycle.
  - nsteps = 63 -> equals the nsteps = 15 result, 5-cycle latency.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_valid and tk1_out stay stable; in_valid pulses in that window are ignored; the result is released on the first out_ready.
- Reset mid-operation: assert rst in the 2nd RUN cycle of nsteps = 15 -> next cycle out_valid = 0, in_ready = 1, tk1_out = 0. A following nsteps = 1 request completes correctly.
- Back-to-back: two requests with in_valid held high and out_ready = 1 -> exactly one idle cycle between out_valid pulses, both results correct.

Source files
------------

// File: rtl/tk1_perm_pkg.sv
// Shared constants for the TK1 H permutation and the rewind FSM state encoding.
package tk1_perm_pkg;

    localparam int unsigned CELL_W = 4;
    localparam int unsigned NCELLS = 16;
    localparam int unsigned TK_W   = CELL_W * NCELLS;

    // Forward H: out[i] = in[P_IDX[i]]; inverse H: out[i] = in[Q_IDX[i]].
    localparam int unsigned P_IDX [NCELLS] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
    localparam int unsigned Q_IDX [NCELLS] = '{8, 9, 10, 11, 12, 13, 14, 15, 2, 0, 4, 7, 6, 3, 5, 1};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/hperm_inv.sv
// One combinational inverse-H step over the 16 nibble cells (cell 0 is the MSB nibble).
module hperm_inv
    import tk1_perm_pkg::*;
(
    input  logic [TK_W-1:0] din,
    output logic [TK_W-1:0] dout
);

    for (genvar i = 0; i < NCELLS; i++) begin : g_cell
        assign dout[TK_W-1-CELL_W*i -: CELL_W] = din[TK_W-1-CELL_W*Q_IDX[i] -: CELL_W];
    end

endmodule

// File: rtl/tk1_rewind.sv
// Iterative TK1 rewind: undoes nsteps mod 16 forward-H steps, STEPS_PER_CYCLE per RUN cycle.
module tk1_rewind
    import tk1_perm_pkg::*;
#(
    parameter int unsigned STEPS_PER_CYCLE = 4,
    parameter int unsigned CNT_W           = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TK_W-1:0]  tk1_in,
    input  logic [CNT_W-1:0] nsteps,
    input  logic             ad,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TK_W-1:0]  tk1_out
);

    localparam int unsigned SEL_W = $clog2(STEPS_PER_CYCLE + 1);
    localparam logic [4:0]  SPC5  = 5'(STEPS_PER_CYCLE);

    state_e            state_q, state_d;
    logic [TK_W-1:0]   tk_q, tk_d;
    logic [TK_W-1:0]   out_q, out_d;
    logic [3:0]        rem_q, rem_d;
    logic [3:0]        r_in;
    logic [3:0]        rem_after;
    logic [SEL_W-1:0]  sel;
    logic [TK_W-1:0]   step_tk;
    logic [TK_W-1:0]   chain [STEPS_PER_CYCLE+1];
    logic              unused_nsteps_hi;

    // H has order 16, so only the low four bits of the count matter.
    assign r_in             = ad ? 4'd0 : nsteps[3:0];
    assign unused_nsteps_hi = ^nsteps[CNT_W-1:4];

    assign chain[0] = tk_q;
    for (genvar s = 0; s < STEPS_PER_CYCLE; s++) begin : g_stage
        hperm_inv u_stage (
            .din  (chain[s]),
            .dout (chain[s+1])
        );
    end

    always_comb begin
        if ({1'b0, rem_q} >= SPC5) begin
            sel = SEL_W'(STEPS_PER_CYCLE);
        end else begin
            sel = SEL_W'(rem_q);
        end
    end

    always_comb begin
        step_tk = chain[0];
        for (int unsigned j = 1; j <= STEPS_PER_CYCLE; j++) begin
            if (sel == SEL_W'(j)) begin
                step_tk = chain[j];
            end
        end
    end

    assign rem_after = rem_q - 4'(sel);

    always_comb begin
        state_d = state_q;
        tk_d    = tk_q;
        rem_d   = rem_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    tk_d  = tk1_in;
                    rem_d = r_in;
                    if (r_in == 4'd0) begin
                        state_d = DONE;
                        out_d   = tk1_in;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                tk_d  = step_tk;
                rem_d = rem_after;
                if (rem_after == 4'd0) begin
                    state_d = DONE;
                    out_d   = step_tk;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tk_q    <= '0;
            rem_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            tk_q    <= tk_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign tk1_out   = out_q;

endmodule

// File: tb/tb_tk1_rewind.sv
// Scoreboard bench for tk1_rewind: driver queues expected results, monitor checks data and latency.
module tb_tk1_rewind;
    import tk1_perm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        ad = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] tk1_in = '0;
    logic [5:0]  nsteps = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] tk1_out;

    tk1_rewind #(
        .STEPS_PER_CYCLE (4),
        .CNT_W           (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tk1_in    (tk1_in),
        .nsteps    (nsteps),
        .ad        (ad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tk1_out   (tk1_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] exp;
        int          lat;
        int          hs;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nfail = 0;
    int   prev_rise = 0;
    int   last_rise = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] fwd(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) begin
            r[63-4*i -: 4] = x[63-4*int'(P_IDX[i]) -: 4];
        end
        return r;
    endfunction

    function automatic logic [63:0] fwdn(input logic [63:0] x, input int n);
        logic [63:0] r = x;
        for (int i = 0; i < n; i++) r = fwd(r);
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic [63:0] t, input logic [5:0] n, input logic a,
                        input logic [63:0] e, input bit push, input bit hold);
        int   to = 0;
        exp_t x;
        tk1_in   = t;
        nsteps   = n;
        ad       = a;
        in_valid = 1'b1;
        while (!in_ready && to < 50) begin
            @(negedge clk);
            to++;
        end
        chk("accept_timeout", 64'(in_ready), 64'd1);
        if (push) begin
            x.exp = e;
            x.lat = a ? 1 : (int'(n[3:0]) + 3) / 4 + 1;
            x.hs  = cyc + 1;
            q.push_back(x);
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int to = 0;
        while (q.size() > 0 && to < 100) begin
            @(negedge clk);
            to++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic monitor();
        logic pv = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (out_valid && !pv) begin
                    prev_rise = last_rise;
                    last_rise = cyc;
                    if (q.size() == 0) begin
                        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        chk("latency", 64'(cyc - q[0].hs + 1), 64'(q[0].lat));
                    end
                end
                if (out_valid && out_ready && q.size() > 0) begin
                    chk("result", tk1_out, q[0].exp);
                    void'(q.pop_front());
                end
                pv = out_valid;
            end
        end
    endtask

    task automatic run_stim();
        logic [63:0] y, x;
        logic [5:0]  n;
        int          to;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_tk1_out", tk1_out, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        send(64'h0123456789ABCDEF, 6'd1, 1'b0, 64'h89ABCDEF20476351, 1, 0);
        drain();
        send(64'h9F8DAECB01234567, 6'd1, 1'b0, 64'h0123456789ABCDEF, 1, 0);
        drain();

        y = 64'h1357_9BDF_0246_8ACE;
        send(y, 6'd16, 1'b0, y, 1, 0);
        drain();
        send(y, 6'd5, 1'b1, y, 1, 0);
        drain();
        send(y, 6'd15, 1'b0, fwd(y), 1, 0);
        drain();
        send(y, 6'd63, 1'b0, fwd(y), 1, 0);
        drain();
        send(y, 6'd48, 1'b0, y, 1, 0);
        drain();

        for (int i = 0; i < 10; i++) begin
            x = {$urandom(), $urandom()};
            n = 6'($urandom_range(0, 63));
            send(fwdn(x, int'(n)), n, 1'b0, x, 1, 0);
            drain();
        end

        // Backpressure: result held, new requests ignored.
        x = 64'hDEADBEEFCAFEF00D;
        out_ready = 1'b0;
        send(fwdn(x, 5), 6'd5, 1'b0, x, 1, 0);
        to = 0;
        while (!out_valid && to < 20) begin
            @(negedge clk);
            to++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_tk1_out", tk1_out, x);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            in_valid = (i % 2 == 0);
            tk1_in   = ~x;
            nsteps   = 6'd0;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset in the second RUN cycle of a 15-step rewind.
        x = 64'h0F1E2D3C4B5A6978;
        send(fwdn(x, 15), 6'd15, 1'b0, 64'd0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_tk1_out", tk1_out, 64'd0);
        send(fwd(x), 6'd1, 1'b0, x, 1, 0);
        drain();

        // Back-to-back with in_valid held high.
        x = 64'hA5A5_5A5A_0FF0_F00F;
        y = 64'h1122_3344_5566_7788;
        send(x, 6'd0, 1'b0, x, 1, 1);
        send(y, 6'd32, 1'b0, y, 1, 0);
        drain();
        chk("b2b_gap", 64'(last_rise - prev_rise), 64'd2);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        fork
            run_stim();
            monitor();
            begin
                #2000000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1);
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
